// File: rtl/ps2_scan_sequencer_pkg.sv
// Shared scan-code constants, pause skip length, event layout and FSM state
// encoding for the PS/2 scan sequencer.
package ps2_scan_sequencer_pkg;

   localparam logic [7:0] SC_00 = 8'h00;
   localparam logic [7:0] SC_AA = 8'hAA;
   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_EE = 8'hEE;
   localparam logic [7:0] SC_F0 = 8'hF0;
   localparam logic [7:0] SC_FA = 8'hFA;
   localparam logic [7:0] SC_FE = 8'hFE;
   localparam logic [7:0] SC_FF = 8'hFF;

   // Bytes following E1 in the Pause sequence that are swallowed
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   localparam int EVT_W = 10;

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } evt_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } state_e;

   // Keyboard status/ack bytes that never become key events
   function automatic logic isDroppedByte(input logic [7:0] b);
      return (b == SC_00) || (b == SC_AA) || (b == SC_EE) ||
             (b == SC_FA) || (b == SC_FE) || (b == SC_FF);
   endfunction

endpackage

// File: rtl/ps2_scan_sequencer_evt_fifo.sv
// Key-event FIFO: circular buffer with one extra pointer bit to tell full
// from empty; head fields read as zero while empty.
module ps2_evt_fifo
   import ps2_scan_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [EVT_W-1:0] data_i,
   output logic [EVT_W-1:0] data_o,
   output logic             valid_o,
   output logic             full_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic             empty;
   logic             doPush;
   logic             doPop;

   assign empty  = (wrPtr_q == rdPtr_q);
   assign full_o = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

   // A pop frees the head slot, so a push into a full FIFO still lands
   assign doPop  = pop_i && !empty;
   assign doPush = push_i && (!full_o || doPop);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
   end

   assign valid_o = !empty;
   assign data_o  = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Turns a stream of PS/2 set-2 scan bytes into key events {code, break, ext}
// and buffers them in a small FIFO for the consumer.
module ps2_scan_sequencer
   import ps2_scan_sequencer_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic [7:0] evt_code,
   output logic       evt_break,
   output logic       evt_ext,
   output logic       evt_valid,
   input  logic       evt_pop,
   output logic       overflow,
   output logic       busy
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_e        state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          overflow_q, overflow_d;
   logic          timeoutHit;
   logic          push;
   evt_t          pushEvt;
   evt_t          headEvt;
   logic          fifoFull;

   assign timeoutHit = (state_q != ST_IDLE) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   // rx_err beats rx_valid; a timeout only matters on a cycle with no byte
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      push    = 1'b0;
      pushEvt = '0;
      if (rx_err) begin
         state_d = ST_IDLE;
         skip_d  = '0;
      end else if (rx_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_byte == SC_E0) begin
                  state_d = ST_EXT;
               end else if (rx_byte == SC_F0) begin
                  state_d = ST_BRK;
               end else if (rx_byte == SC_E1) begin
                  state_d = ST_PAUSE;
                  skip_d  = PAUSE_SKIP;
               end else if (!isDroppedByte(rx_byte)) begin
                  push    = 1'b1;
                  pushEvt = '{code: rx_byte, brk: 1'b0, ext: 1'b0};
               end
            end
            ST_EXT: begin
               if (rx_byte == SC_F0) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  push    = 1'b1;
                  pushEvt = '{code: rx_byte, brk: 1'b0, ext: 1'b1};
                  state_d = ST_IDLE;
               end
            end
            ST_BRK: begin
               push    = 1'b1;
               pushEvt = '{code: rx_byte, brk: 1'b1, ext: 1'b0};
               state_d = ST_IDLE;
            end
            ST_EXT_BRK: begin
               push    = 1'b1;
               pushEvt = '{code: rx_byte, brk: 1'b1, ext: 1'b1};
               state_d = ST_IDLE;
            end
            ST_PAUSE: begin
               if (skip_q <= 3'd1) begin
                  push    = 1'b1;
                  pushEvt = '{code: SC_E1, brk: 1'b0, ext: 1'b1};
                  skip_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  skip_d = skip_q - 3'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (timeoutHit) begin
         state_d = ST_IDLE;
         skip_d  = '0;
      end
   end

   always_comb begin
      tcnt_d = tcnt_q + 1'b1;
      if (rx_valid || rx_err || timeoutHit || state_q == ST_IDLE) tcnt_d = '0;
   end

   // A full FIFO with a pop in the same cycle still accepts the push
   always_comb begin
      overflow_d = overflow_q;
      if (push && fifoFull && !evt_pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         skip_q     <= '0;
         tcnt_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         skip_q     <= skip_d;
         tcnt_q     <= tcnt_d;
         overflow_q <= overflow_d;
      end
   end

   ps2_evt_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (evt_pop),
      .data_i  (pushEvt),
      .data_o  (headEvt),
      .valid_o (evt_valid),
      .full_o  (fifoFull)
   );

   assign evt_code  = headEvt.code;
   assign evt_break = headEvt.brk;
   assign evt_ext   = headEvt.ext;
   assign overflow  = overflow_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: a per-cycle vector table for the
// basic sequences plus hand-written timeout, FIFO, error and reset cases.
module tb_ps2_scan_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rxByte;
   logic       rxValid;
   logic       rxErr;
   logic [7:0] evtCode;
   logic       evtBreak;
   logic       evtExt;
   logic       evtValid;
   logic       evtPop;
   logic       overflow;
   logic       busy;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic [7:0] rxByte;
      logic       rxValid;
      logic       rxErr;
      logic       pop;
      logic       expValid;
      logic [7:0] expCode;
      logic       expBreak;
      logic       expExt;
      logic       expBusy;
   } vec_t;

   vec_t vecs[$];

   ps2_scan_sequencer #(
      .FIFO_DEPTH    (4),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_byte   (rxByte),
      .rx_valid  (rxValid),
      .rx_err    (rxErr),
      .evt_code  (evtCode),
      .evt_break (evtBreak),
      .evt_ext   (evtExt),
      .evt_valid (evtValid),
      .evt_pop   (evtPop),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [7:0] b, input logic v, input logic e,
                               input logic p, input logic ev, input logic [7:0] ec,
                               input logic eb, input logic ex, input logic bz);
      vec_t r;
      r.rxByte = b;  r.rxValid = v;   r.rxErr = e;    r.pop = p;
      r.expValid = ev; r.expCode = ec; r.expBreak = eb; r.expExt = ex;
      r.expBusy = bz;
      return r;
   endfunction

   // Drive one cycle of inputs, let the edge happen, sample #1 later
   task automatic applyStimulus(input logic [7:0] b, input logic v, input logic e,
                                input logic p);
      @(negedge clk);
      rxByte  = b;
      rxValid = v;
      rxErr   = e;
      evtPop  = p;
      @(posedge clk);
      #1;
      rxValid = 1'b0;
      rxErr   = 1'b0;
      evtPop  = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic expValid,
                              input logic [7:0] expCode, input logic expBreak,
                              input logic expExt, input logic expBusy,
                              input logic expOvf);
      assertCount++;
      if ({evtValid, evtCode, evtBreak, evtExt} !== {expValid, expCode, expBreak, expExt}) begin
         failCount++;
         $display("[TB] FAIL %s event: got v=%b code=%h brk=%b ext=%b, want v=%b code=%h brk=%b ext=%b",
                  name, evtValid, evtCode, evtBreak, evtExt, expValid, expCode, expBreak, expExt);
      end
      assertCount++;
      if ({busy, overflow} !== {expBusy, expOvf}) begin
         failCount++;
         $display("[TB] FAIL %s status: got busy=%b ovf=%b, want busy=%b ovf=%b",
                  name, busy, overflow, expBusy, expOvf);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      rxByte  = 8'h00;
      rxValid = 1'b0;
      rxErr   = 1'b0;
      evtPop  = 1'b0;

      //                byte  v  e  p   expV code  brk ext busy
      vecs.push_back(mk(8'h1C,1,0,0, 1,8'h1C,0,0,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hF0,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h1C,1,0,0, 1,8'h1C,1,0,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hE0,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h75,1,0,0, 1,8'h75,0,1,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hE0,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'hF0,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h75,1,0,0, 1,8'h75,1,1,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hAA,1,0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hFA,1,0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'h00,1,0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hFF,1,0,0, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'hE1,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h14,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h77,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'hE1,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'hF0,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h14,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'hF0,1,0,0, 0,8'h00,0,0,1));
      vecs.push_back(mk(8'h77,1,0,0, 1,8'hE1,0,1,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'h2A,1,0,0, 1,8'h2A,0,0,0));
      vecs.push_back(mk(8'h3B,1,0,1, 1,8'h3B,0,0,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));
      vecs.push_back(mk(8'h00,0,0,1, 0,8'h00,0,0,0));

      doReset();
      checkOutput("reset", 0, 8'h00, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rxByte, vecs[i].rxValid, vecs[i].rxErr, vecs[i].pop);
         checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCode,
                     vecs[i].expBreak, vecs[i].expExt, vecs[i].expBusy, 1'b0);
      end

      // Timeout: still waiting after 15 idle cycles, abandoned after the 16th
      applyStimulus(8'hF0, 1, 0, 0);
      for (int i = 0; i < 15; i++) applyStimulus(8'h00, 0, 0, 0);
      checkOutput("tmo_15", 0, 8'h00, 0, 0, 1, 0);
      applyStimulus(8'h00, 0, 0, 0);
      checkOutput("tmo_16", 0, 8'h00, 0, 0, 0, 0);
      applyStimulus(8'h1C, 1, 0, 0);
      checkOutput("tmo_make", 1, 8'h1C, 0, 0, 0, 0);
      applyStimulus(8'h00, 0, 0, 1);
      checkOutput("tmo_drain", 0, 8'h00, 0, 0, 0, 0);

      // Full FIFO with simultaneous push and pop keeps all four slots in use
      for (int i = 0; i < 4; i++) applyStimulus(8'h20 + 8'(i), 1, 0, 0);
      checkOutput("full_head", 1, 8'h20, 0, 0, 0, 0);
      applyStimulus(8'h24, 1, 0, 1);
      checkOutput("full_pushpop", 1, 8'h21, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("full_drain%0d", i), 1, 8'h21 + 8'(i), 0, 0, 0, 0);
         applyStimulus(8'h00, 0, 0, 1);
      end
      checkOutput("full_empty", 0, 8'h00, 0, 0, 0, 0);

      // Overflow: fifth make code is dropped and the flag sticks
      for (int i = 0; i < 4; i++) applyStimulus(8'h15 + 8'(i), 1, 0, 0);
      checkOutput("ovf_4", 1, 8'h15, 0, 0, 0, 0);
      applyStimulus(8'h19, 1, 0, 0);
      checkOutput("ovf_5", 1, 8'h15, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ovf_pop%0d", i), 1, 8'h15 + 8'(i), 0, 0, 0, 1);
         applyStimulus(8'h00, 0, 0, 1);
      end
      checkOutput("ovf_empty", 0, 8'h00, 0, 0, 0, 1);

      // rx_err beats rx_valid on the byte after F0
      applyStimulus(8'hF0, 1, 0, 0);
      applyStimulus(8'h1C, 1, 1, 0);
      checkOutput("err_drop", 0, 8'h00, 0, 0, 0, 1);

      // Reset mid-E0 with an event pending discards everything
      applyStimulus(8'h33, 1, 0, 0);
      applyStimulus(8'hE0, 1, 0, 0);
      checkOutput("pre_reset", 1, 8'h33, 0, 0, 1, 1);
      doReset();
      checkOutput("mid_reset", 0, 8'h00, 0, 0, 0, 0);
      applyStimulus(8'h75, 1, 0, 0);
      checkOutput("post_reset", 1, 8'h75, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/ps2_scan_sequencer.md
PS2_SCAN_SEQUENCER -- requirements
Module: ps2_scan_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of key-event entries buffered (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, idle clk cycles after which a partial prefix sequence is abandoned.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_byte  input  8  scan byte from PS/2 frame receiver.
REQ-006 rx_valid  input  1  one-cycle pulse; rx_byte valid, parity good.
REQ-007 rx_err  input  1  one-cycle pulse; frame or parity error on last frame.
REQ-008 evt_code  output  8  key code at FIFO head (prefix bytes stripped).
REQ-009 evt_break  output  1  head event is a key release.
REQ-010 evt_ext  output  1  head event carried the E0 or E1 prefix.
REQ-011 evt_valid  output  1  FIFO non-empty; evt_* fields valid.
REQ-012 evt_pop  input  1  consumer takes the head entry this cycle.
REQ-013 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-014 busy  output  1  sequencer is mid-sequence (state != IDLE).

Function
REQ-015 The FSM SHALL have states IDLE, EXT, BRK, EXT_BRK, and PAUSE.
REQ-016 IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter = 7; 00, AA, EE, FA, FE, FF are dropped and the FSM stays in IDLE; any other byte pushes {code, break=0, ext=0} and the FSM stays in IDLE.
REQ-017 EXT: F0 -> EXT_BRK; any other byte pushes {code, 0, 1} and the FSM goes to IDLE.
REQ-018 BRK: any byte pushes {code, 1, 0} and the FSM goes to IDLE.
REQ-019 EXT_BRK: any byte pushes {code, 1, 1} and the FSM goes to IDLE.
REQ-020 PAUSE: each rx_valid decrements the skip counter; when the counter reaches 0, the block pushes {E1, 0, 1} and the FSM goes to IDLE.
REQ-021 A push SHALL make evt_valid visible the cycle after the rx_valid carrying the final byte (1-cycle latency).
REQ-022 rx_err in any state SHALL return the FSM to IDLE without a push; if rx_err and rx_valid are asserted in the same cycle, rx_err wins.
REQ-023 Timeout: a counter SHALL clear on every rx_valid and increment while state != IDLE; on reaching TIMEOUT_CYCLES-1 the FSM goes to IDLE without a push.
REQ-024 A push with the FIFO full and no pop SHALL drop the new event, set overflow, and leave the FIFO unchanged.
REQ-025 Push and pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-026 evt_pop while the FIFO is empty SHALL be ignored.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with one extra bit.
REQ-028 evt_code, evt_break, and evt_ext SHALL be 0 whenever evt_valid = 0.

Reset
REQ-029 With reset asserted at a clk edge: state = IDLE, FIFO empty, evt_valid = 0, evt_* = 0, overflow = 0, busy = 0, timeout and skip counters = 0.
REQ-030 Reset mid-sequence or with a non-empty FIFO SHALL discard everything; no event is emitted for a partial sequence.
REQ-031 overflow SHALL clear only on reset.

Structure
REQ-032 A shared package SHALL hold the scan constants (E0, E1, F0, AA, FA, FE, EE, 00, FF), the pause skip length 7, and the FSM state encoding.
REQ-033 The FIFO SHALL be a sub-module ps2_evt_fifo (10-bit entries, FIFO_DEPTH parameter) instantiated once; the FSM and timeout logic stay in ps2_scan_sequencer.

Verification
REQ-034 Bytes 1C, then F0 1C -> events {1C,0,0} then {1C,1,0}; evt_valid rises 1 cycle after each final rx_valid.
REQ-035 Bytes E0 75, then E0 F0 75 -> events {75,0,1} then {75,1,1}; busy = 1 between prefix and final byte.
REQ-036 Bytes AA, FA, then E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,1}; no event for AA or FA.
REQ-037 With TIMEOUT_CYCLES = 16: F0 then 16 idle cycles then 1C -> the single event is {1C,0,0}.
REQ-038 With no pops, 5 make codes 15 16 17 18 19 and FIFO_DEPTH = 4 -> overflow = 1; popping yields 15 16 17 18, then evt_valid = 0.
REQ-039 F0 with rx_err asserted during the following byte, and reset asserted mid-E0 -> no events; state IDLE and all outputs 0 after reset.
